// File: rtl/fp_add_arbiter.sv
// Round-robin front end that time-shares one combinational FP32 adder among NUM_REQ requesters.
// Optional macro FP_ADD_ARB_ZERO_BYPASS_EN answers zero-operand requests locally without using the adder.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_op,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_op,
  input  logic [31:0]          add_sum,
  input  logic                 add_zero,
  input  logic                 add_overflow,
  input  logic                 add_underflow,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_sum,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_zero,
  output logic                 resp_overflow,
  output logic                 resp_underflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t              state, next_state;
  logic [ID_W-1:0]     ptr, cur_id, grant_id;
  logic [NUM_REQ-1:0]  grant;
  logic                found, accept;
  logic [ID_W:0]       cand;
  logic [31:0]         op_a, op_b;
  logic                op_op;
  logic [31:0]         sel_a, sel_b;
  logic                sel_op;
  logic                bypass;
  logic [31:0]         bypass_sum;

  // Search upward from ptr+1 with wrap, so the last winner has lowest priority.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found                     = 1'b1;
        grant[cand[ID_W-1:0]]     = 1'b1;
        grant_id                  = cand[ID_W-1:0];
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_a     = req_a[{grant_id, 5'b0} +: 32];
  assign sel_b     = req_b[{grant_id, 5'b0} +: 32];
  assign sel_op    = req_op[grant_id];

  assign add_a  = op_a;
  assign add_b  = op_b;
  assign add_op = op_op;

`ifdef FP_ADD_ARB_ZERO_BYPASS_EN
  logic a_is_zero, b_is_zero;
  assign a_is_zero  = (sel_a[30:0] == 31'd0);
  assign b_is_zero  = (sel_b[30:0] == 31'd0);
  assign bypass     = a_is_zero | b_is_zero;
  // A zero operand reduces the result to the other operand (negated for A-B).
  assign bypass_sum = (a_is_zero && b_is_zero) ? 32'h0000_0000 :
                      a_is_zero ? {sel_b[31] ^ sel_op, sel_b[30:0]} : sel_a;
`else
  assign bypass     = 1'b0;
  assign bypass_sum = 32'h0000_0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = bypass ? RESP : EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= ID_W'(NUM_REQ-1);
      cur_id         <= '0;
      op_a           <= '0;
      op_b           <= '0;
      op_op          <= 1'b0;
      resp_valid     <= 1'b0;
      resp_sum       <= '0;
      resp_id        <= '0;
      resp_zero      <= 1'b0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a   <= sel_a;
          op_b   <= sel_b;
          op_op  <= sel_op;
          cur_id <= grant_id;
          ptr    <= grant_id;
          if (bypass) begin
            resp_sum       <= bypass_sum;
            resp_zero      <= (bypass_sum[30:0] == 31'd0);
            resp_overflow  <= 1'b0;
            resp_underflow <= 1'b0;
            resp_id        <= grant_id;
            resp_valid     <= 1'b1;
          end
        end
        EXEC: begin
          resp_sum       <= add_sum;
          resp_zero      <= add_zero;
          resp_overflow  <= add_overflow;
          resp_underflow <= add_underflow;
          resp_id        <= cur_id;
          resp_valid     <= 1'b1;
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
